cpu_1: RTL and testbench
========================

CPU_1 -- requirements
Module: cpu_1

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 64, instruction ROM depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 64, data RAM depth in 32-bit words.
REQ-003 SHALL have parameter SCAN_DIV, default 4, or_CLK cycles per display digit.
REQ-004 SHALL be clocked by a single clock, or_CLK, with asynchronous active-high reset Reset.
- or_CLK  input  1  sole clock, rising edge
- Reset  input  1  asynchronous, active-high
REQ-005 SHALL have the remaining ports:
- CLK  input  1  single-step strobe; each rising edge executes one instruction; not a clock
- sw  input  2  display select
- dispcode  output  8  segments; [6:0]=g..a, [7]=dp; active-low
- sign_1..sign_4  output  1 each  digit enables, active-low; sign_1 is the leftmost digit

Function
REQ-006 SHALL synchronize CLK with two or_CLK flops and generate a one-cycle step pulse on a 0->1 transition.
REQ-007 SHALL commit PC, register-file and RAM writes only in the or_CLK cycle of the step pulse, executing exactly one instruction per pulse.
REQ-008 SHALL implement a 32-bit single-cycle MIPS subset:
- R-type: add, sub, and, or, slt (signed)
- I-type: addi, ori (zero-extended immediate), lw, sw, beq
- J-type: j
REQ-009 SHALL use a byte-addressed PC that advances by 4, with word-indexed ROM/RAM (address bits [7:2]) and 8-bit wrap-around.
REQ-010 SHALL compute beq target = PC+4+(signext(imm)<<2) and j target = {PC+4[31:28], addr, 2'b00}.
REQ-011 SHALL make add/addi wrap modulo 2^32 with no overflow trap, and SHALL treat undefined opcodes as NOPs.
REQ-012 SHALL hold register $0 at 0 and ignore writes to it.
REQ-013 SHALL use a combinational register-file read, with the write committed on the step cycle.
REQ-014 SHALL initialize the ROM with the default program (word index: instruction):
- 0: addi $1,$0,5
- 1: addi $2,$0,3
- 2: add $3,$1,$2
- 3: sw $3,0($0)
- 4: lw $4,0($0)
- 5: beq $4,$3,+1
- 6: addi $5,$0,1
- 7: j 7
REQ-015 SHALL fill all other ROM words with 0 (NOP).
REQ-016 SHALL show four hex digits, left to right, selected by sw:
- 00: PC[7:0], nextPC[7:0]
- 01: rs index[4:0] zero-extended to 8 bits, rs value[7:0]
- 10: rt index, rt value[7:0]
- 11: ALU result[7:0], writeback data[7:0]
REQ-017 SHALL drive the display from the current combinational state and update immediately when sw changes.
REQ-018 SHALL scan digits round-robin sign_1..sign_4, advancing one digit per SCAN_DIV or_CLK cycles, with exactly one sign low at a time.
REQ-019 SHALL hold dispcode[7] (dp) at 1.
REQ-020 SHALL use these hex encodings: 0=0xC0, 3=0xB0, 5=0x92, 8=0x80, C=0xC6; all 16 digits standard.

Reset
REQ-021 SHALL, while Reset=1, force PC=0, all registers to 0, the scan counter to digit 1 (sign_1=0, others 1), and the step synchronizer to 0.
REQ-022 SHALL leave RAM contents unaffected by Reset.
REQ-023 SHALL ignore a CLK edge coincident with Reset, and SHALL need a fresh 0->1 edge after Reset deasserts before executing.
REQ-024 SHALL take effect asynchronously when Reset is asserted mid-instruction, discarding that instruction's writes.

Verification
REQ-025 SHALL be checked with these directed scenarios:
- Reset=1 with sw=00 -> PC=0x00, digits "0004", sign_1 low, dispcode=0xC0.
- Reset released, 3 CLK rising edges -> $3=8, PC=0x0C; sw=11 after edge 2 (before edge 3) -> ALU/WB digits show 08.
- Steps 4-5 (sw, lw) -> $4=8, RAM[0]=8.
- Step 6 (beq taken) -> PC=0x1C, $5 stays 0; extra steps -> PC stays 0x1C (j 7).
- Reset pulsed mid-program -> PC=0 and registers 0 immediately; re-run reproduces the same values.
- CLK held high for many or_CLK cycles -> exactly one instruction executes.

Source files
------------

// File: rtl/cpu_1.sv
// Single-step 32-bit MIPS subset with a built-in program ROM and a scanned 4-digit hex display.
// Each synchronized rising edge on CLK commits one instruction; or_CLK runs everything.
module cpu_1 #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  parameter int SCAN_DIV   = 4
) (
  input  logic       or_CLK,
  input  logic       Reset,
  input  logic       CLK,
  input  logic [1:0] sw,
  output logic [7:0] dispcode,
  output logic       sign_1,
  output logic       sign_2,
  output logic       sign_3,
  output logic       sign_4
);

  logic [1:0]  sync_q, fill_q;
  logic        prev_q, armed_q, step;
  logic [7:0]  pc_q, pc_d, pc_plus4;
  logic [31:0] rf_q [32];
  logic [31:0] mem_q [DMEM_WORDS];
  logic [31:0] instr, rs_val, rt_val, simm, zimm, alu, wb, ram_rd;
  logic [5:0]  op, funct, daddr;
  logic [4:0]  rs_idx, rt_idx, rd_idx, wr_idx;
  logic        reg_we, mem_we, mem_rd;
  logic [15:0] div_q, disp_word;
  logic [1:0]  digit_q;
  logic [3:0]  nibble;

  // The edge detector only arms once a settled low level has been seen,
  // so a CLK already high across Reset cannot fire a step.
  always_ff @(posedge or_CLK or posedge Reset) begin
    if (Reset) begin
      sync_q  <= 2'b00;
      fill_q  <= 2'b00;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], CLK};
      fill_q <= {fill_q[0], 1'b1};
      prev_q <= sync_q[1];
      if (fill_q[1] && !sync_q[1]) armed_q <= 1'b1;
    end
  end

  assign step = armed_q && sync_q[1] && !prev_q;

  function automatic logic [31:0] rom_word(input logic [5:0] idx);
    logic [31:0] w;
    case (idx)
      6'd0:    w = 32'h2001_0005;
      6'd1:    w = 32'h2002_0003;
      6'd2:    w = 32'h0022_1820;
      6'd3:    w = 32'hAC03_0000;
      6'd4:    w = 32'h8C04_0000;
      6'd5:    w = 32'h1083_0001;
      6'd6:    w = 32'h2005_0001;
      6'd7:    w = 32'h0800_0007;
      default: w = 32'h0000_0000;
    endcase
    if (int'(idx) >= IMEM_WORDS) w = 32'h0000_0000;
    return w;
  endfunction

  assign instr    = rom_word(pc_q[7:2]);
  assign op       = instr[31:26];
  assign rs_idx   = instr[25:21];
  assign rt_idx   = instr[20:16];
  assign rd_idx   = instr[15:11];
  assign funct    = instr[5:0];
  assign simm     = {{16{instr[15]}}, instr[15:0]};
  assign zimm     = {16'h0000, instr[15:0]};
  assign rs_val   = rf_q[rs_idx];
  assign rt_val   = rf_q[rt_idx];
  assign pc_plus4 = pc_q + 8'd4;

  always_comb begin
    alu    = 32'h0;
    reg_we = 1'b0;
    mem_we = 1'b0;
    mem_rd = 1'b0;
    wr_idx = rt_idx;
    pc_d   = pc_plus4;
    case (op)
      6'h00: begin
        wr_idx = rd_idx;
        case (funct)
          6'h20: begin alu = rs_val + rt_val; reg_we = 1'b1; end
          6'h22: begin alu = rs_val - rt_val; reg_we = 1'b1; end
          6'h24: begin alu = rs_val & rt_val; reg_we = 1'b1; end
          6'h25: begin alu = rs_val | rt_val; reg_we = 1'b1; end
          6'h2A: begin
            alu    = {31'h0, $signed(rs_val) < $signed(rt_val)};
            reg_we = 1'b1;
          end
          default: ;
        endcase
      end
      6'h08: begin alu = rs_val + simm; reg_we = 1'b1; end
      6'h0D: begin alu = rs_val | zimm; reg_we = 1'b1; end
      6'h23: begin alu = rs_val + simm; reg_we = 1'b1; mem_rd = 1'b1; end
      6'h2B: begin alu = rs_val + simm; mem_we = 1'b1; end
      6'h04: begin
        alu = rs_val - rt_val;
        if (alu == 32'h0) pc_d = pc_plus4 + {simm[5:0], 2'b00};
      end
      6'h02: pc_d = {instr[5:0], 2'b00};
      default: ;
    endcase
  end

  assign daddr  = alu[7:2];
  assign ram_rd = (int'(daddr) < DMEM_WORDS) ? mem_q[daddr] : 32'h0;
  assign wb     = mem_rd ? ram_rd : alu;

  always_ff @(posedge or_CLK or posedge Reset) begin
    if (Reset) begin
      pc_q <= 8'h00;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (step) begin
      pc_q <= pc_d;
      if (reg_we && wr_idx != 5'd0) rf_q[wr_idx] <= wb;
    end
  end

  // Data RAM keeps its contents across Reset.
  always_ff @(posedge or_CLK) begin
    if (!Reset && step && mem_we && int'(daddr) < DMEM_WORDS) mem_q[daddr] <= rt_val;
  end

  always_ff @(posedge or_CLK or posedge Reset) begin
    if (Reset) begin
      div_q   <= 16'h0;
      digit_q <= 2'd0;
    end else if (div_q == 16'(SCAN_DIV - 1)) begin
      div_q   <= 16'h0;
      digit_q <= digit_q + 2'd1;
    end else begin
      div_q <= div_q + 16'h1;
    end
  end

  always_comb begin
    case (sw)
      2'b00:   disp_word = {pc_q, pc_d};
      2'b01:   disp_word = {3'b000, rs_idx, rs_val[7:0]};
      2'b10:   disp_word = {3'b000, rt_idx, rt_val[7:0]};
      default: disp_word = {alu[7:0], wb[7:0]};
    endcase
    case (digit_q)
      2'd0:    nibble = disp_word[15:12];
      2'd1:    nibble = disp_word[11:8];
      2'd2:    nibble = disp_word[7:4];
      default: nibble = disp_word[3:0];
    endcase
    case (nibble)
      4'h0: dispcode = 8'hC0;  4'h1: dispcode = 8'hF9;
      4'h2: dispcode = 8'hA4;  4'h3: dispcode = 8'hB0;
      4'h4: dispcode = 8'h99;  4'h5: dispcode = 8'h92;
      4'h6: dispcode = 8'h82;  4'h7: dispcode = 8'hF8;
      4'h8: dispcode = 8'h80;  4'h9: dispcode = 8'h90;
      4'hA: dispcode = 8'h88;  4'hB: dispcode = 8'h83;
      4'hC: dispcode = 8'hC6;  4'hD: dispcode = 8'hA1;
      4'hE: dispcode = 8'h86;  default: dispcode = 8'h8E;
    endcase
  end

  assign sign_1 = (digit_q != 2'd0);
  assign sign_2 = (digit_q != 2'd1);
  assign sign_3 = (digit_q != 2'd2);
  assign sign_4 = (digit_q != 2'd3);

endmodule

// File: tb/tb_cpu_1.sv
// Bench for cpu_1: steps the default program and reads state back by decoding the scanned display.
`timescale 1ns/1ps
module tb_cpu_1;

  logic       or_clk, reset, clk_step;
  logic [1:0] sw;
  logic [7:0] dispcode;
  logic       sign_1, sign_2, sign_3, sign_4;

  int checks = 0;
  int errors = 0;
  int steps_done = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  seg_tab [16];

  typedef struct {
    int          step;
    logic [1:0]  sel;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [26];

  cpu_1 #(.IMEM_WORDS(64), .DMEM_WORDS(64), .SCAN_DIV(4)) dut (
    .or_CLK(or_clk), .Reset(reset), .CLK(clk_step), .sw(sw),
    .dispcode(dispcode), .sign_1(sign_1), .sign_2(sign_2),
    .sign_3(sign_3), .sign_4(sign_4)
  );

  // clock / reset
  initial or_clk = 1'b0;
  always #5 or_clk = ~or_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver: one single-step strobe, CLK held high for 'hold' or_CLK cycles
  task automatic do_step(input int hold);
    @(negedge or_clk) clk_step = 1'b1;
    repeat (hold) @(negedge or_clk);
    clk_step = 1'b0;
    repeat (4) @(negedge or_clk);
    steps_done++;
  endtask

  function automatic int seg2nib(input logic [7:0] s);
    for (int k = 0; k < 16; k++) if (seg_tab[k] == s) return k;
    return -1;
  endfunction

  // Samples one full scan; ok drops on a bad segment code, dp low, or sign not one-hot.
  task automatic read_disp(output logic [15:0] val, output logic ok);
    logic [3:0] d [4];
    logic [3:0] seen;
    int lows, pos, n;
    ok = 1'b1;
    seen = 4'h0;
    for (int k = 0; k < 4; k++) d[k] = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge or_clk);
      lows = 0;
      pos = 0;
      if (!sign_1) begin lows++; pos = 0; end
      if (!sign_2) begin lows++; pos = 1; end
      if (!sign_3) begin lows++; pos = 2; end
      if (!sign_4) begin lows++; pos = 3; end
      if (lows != 1 || dispcode[7] !== 1'b1) ok = 1'b0;
      n = seg2nib(dispcode);
      if (n < 0) ok = 1'b0;
      else d[pos] = n[3:0];
      seen[pos] = 1'b1;
    end
    if (seen != 4'hF) ok = 1'b0;
    val = {d[0], d[1], d[2], d[3]};
  endtask

  // scoreboard: expectation queued when sw is driven, popped once the scan completes
  task automatic run_check(input string name, input logic [1:0] sel, input logic [15:0] exp);
    logic [15:0] got, e;
    logic ok;
    sw = sel;
    exp_q.push_back(exp);
    read_disp(got, ok);
    e = exp_q.pop_front();
    check(name, {15'h0, ok, got}, {15'h0, 1'b1, e});
  endtask

  initial begin
    string nm;
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    vecs = '{
      '{0, 2'b00, 16'h0004}, '{0, 2'b01, 16'h0000}, '{0, 2'b10, 16'h0100}, '{0, 2'b11, 16'h0505},
      '{1, 2'b00, 16'h0408}, '{1, 2'b10, 16'h0200}, '{1, 2'b11, 16'h0303},
      '{2, 2'b00, 16'h080C}, '{2, 2'b01, 16'h0105}, '{2, 2'b10, 16'h0203}, '{2, 2'b11, 16'h0808},
      '{3, 2'b00, 16'h0C10}, '{3, 2'b10, 16'h0308}, '{3, 2'b11, 16'h0000},
      '{4, 2'b00, 16'h1014}, '{4, 2'b10, 16'h0400}, '{4, 2'b11, 16'h0008},
      '{5, 2'b00, 16'h141C}, '{5, 2'b01, 16'h0408}, '{5, 2'b10, 16'h0308}, '{5, 2'b11, 16'h0000},
      '{6, 2'b00, 16'h1C1C}, '{6, 2'b01, 16'h0000}, '{7, 2'b00, 16'h1C1C},
      '{9, 2'b00, 16'h1C1C}, '{9, 2'b10, 16'h0000}
    };

    reset = 1'b1;
    clk_step = 1'b0;
    sw = 2'b00;
    repeat (10) @(negedge or_clk);
    check("reset_signs", {28'h0, sign_1, sign_2, sign_3, sign_4}, 32'h7);
    check("reset_seg", {24'h0, dispcode}, 32'hC0);
    repeat (3) @(negedge or_clk);
    check("reset_seg_hold", {24'h0, dispcode, sign_1}, {24'h0, 8'hC0, 1'b0});
    reset = 1'b0;
    repeat (5) @(negedge or_clk);

    for (int i = 0; i < 26; i++) begin
      while (steps_done < vecs[i].step) do_step(4);
      nm = $sformatf("vec%0d_step%0d_sw%0d", i, vecs[i].step, vecs[i].sel);
      run_check(nm, vecs[i].sel, vecs[i].exp);
    end

    // Reset mid-instruction with CLK high: takes effect at once, and the
    // edge seen across Reset must not execute after release.
    sw = 2'b00;
    @(negedge or_clk) clk_step = 1'b1;
    @(posedge or_clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_signs", {28'h0, sign_1, sign_2, sign_3, sign_4}, 32'h7);
    check("midreset_pc_digit", {24'h0, dispcode}, 32'hC0);
    repeat (4) @(negedge or_clk);
    reset = 1'b0;
    repeat (20) @(negedge or_clk);
    run_check("coincident_edge_ignored", 2'b00, 16'h0004);
    run_check("regs_cleared_r1", 2'b10, 16'h0100);
    clk_step = 1'b0;
    repeat (6) @(negedge or_clk);
    steps_done = 0;

    // Re-run; the third step holds CLK high for a long time.
    do_step(4);
    do_step(4);
    run_check("rerun_alu_wb", 2'b11, 16'h0808);
    do_step(60);
    run_check("long_high_one_step_pc", 2'b00, 16'h0C10);
    run_check("rerun_r3", 2'b10, 16'h0308);
    do_step(4);
    do_step(4);
    run_check("rerun_r4", 2'b01, 16'h0408);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
